// File: rtl/axil_pkg.sv
// Shared response codes, FSM state encodings and the strobed byte-merge helper
// for the AXI4-Lite register-file slave.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

  function automatic logic [31:0] wr_bytes(input logic [31:0] old,
                                           input logic [31:0] data,
                                           input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = data[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axil_regfile.sv
// DEPTH x 32 storage: one byte-strobed write port, one registered read port (1 cycle),
// synchronous clear; a read and write to the same word on one edge returns the old word.
module axil_regfile
  import axil_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       wstrb_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we_i) mem_q[waddr_i] <= wr_bytes(mem_q[waddr_i], wdata_i, wstrb_i);
      if (re_i) rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axil_slave_regfile.sv
// AXI4-Lite slave over a strobed register file; B and R valid one cycle after the last handshake.
// Readies decode from registered state only; each channel holds its response until ready.
module axil_slave_regfile
  import axil_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [2:0]        s_axi_awprot,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [STRB_W-1:0] s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [2:0]        s_axi_arprot,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wr_state_e         wr_state_q;
  logic              aw_held_q, w_held_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;
  rd_state_e         rd_state_q;
  logic              rvalid_q;
  logic [1:0]        rresp_q;
  logic [DATA_W-1:0] rf_rdata;

  logic              wr_idle, aw_hs, w_hs, commit_d, wr_ok_d, rf_we;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;
  logic [STRB_W-1:0] wr_strb_d;
  logic [ADDR_W-3:0] wr_idx_d, rd_idx_d;
  logic              ar_hs, rd_ok_d;

  assign wr_idle       = (wr_state_q == WR_IDLE);
  assign s_axi_awready = s_axi_aresetn && wr_idle && !aw_held_q;
  assign s_axi_wready  = s_axi_aresetn && wr_idle && !w_held_q;
  assign s_axi_arready = s_axi_aresetn && (rd_state_q == RD_IDLE);

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // A handshake on the commit edge counts as held, so take the live bus value then.
  assign wr_addr_d = aw_hs ? s_axi_awaddr : awaddr_q;
  assign wr_data_d = w_hs ? s_axi_wdata : wdata_q;
  assign wr_strb_d = w_hs ? s_axi_wstrb : wstrb_q;
  assign wr_idx_d  = wr_addr_d[ADDR_W-1:2];
  assign wr_ok_d   = wr_idx_d < (ADDR_W-2)'(DEPTH);
  assign commit_d  = wr_idle && (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign rf_we     = commit_d && wr_ok_d;

  assign rd_idx_d = s_axi_araddr[ADDR_W-1:2];
  assign rd_ok_d  = rd_idx_d < (ADDR_W-2)'(DEPTH);

  axil_regfile #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_regfile (
    .clk_i   (s_axi_aclk),
    .rst_ni  (s_axi_aresetn),
    .we_i    (rf_we),
    .waddr_i (wr_idx_d[IDX_W-1:0]),
    .wdata_i (wr_data_d),
    .wstrb_i (wr_strb_d),
    .re_i    (ar_hs && rd_ok_d),
    .raddr_i (rd_idx_d[IDX_W-1:0]),
    .rdata_o (rf_rdata)
  );

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      wr_state_q <= WR_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      case (wr_state_q)
        WR_IDLE: begin
          if (aw_hs) begin
            awaddr_q  <= s_axi_awaddr;
            aw_held_q <= 1'b1;
          end
          if (w_hs) begin
            wdata_q  <= s_axi_wdata;
            wstrb_q  <= s_axi_wstrb;
            w_held_q <= 1'b1;
          end
          if (commit_d) begin
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= wr_ok_d ? RESP_OKAY : RESP_SLVERR;
            wr_state_q <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (s_axi_bready) begin
            bvalid_q   <= 1'b0;
            wr_state_q <= WR_IDLE;
          end
        end
        default: wr_state_q <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      rd_state_q <= RD_IDLE;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (ar_hs) begin
            rvalid_q   <= 1'b1;
            rresp_q    <= rd_ok_d ? RESP_OKAY : RESP_SLVERR;
            rd_state_q <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (s_axi_rready) begin
            rvalid_q   <= 1'b0;
            rd_state_q <= RD_IDLE;
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  // Error reads never load the regfile read register, so mask it to return zero.
  assign s_axi_rdata  = (rresp_q == RESP_OKAY) ? rf_rdata : '0;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_bvalid = bvalid_q;

  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, wr_addr_d[1:0], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Directed AXI4-Lite bench for axil_slave_regfile with hand-computed expectations.
module tb_axil_slave_regfile;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axil_slave_regfile dut (
    .s_axi_aclk    (clk),
    .s_axi_aresetn (aresetn),
    .s_axi_awaddr  (awaddr),
    .s_axi_awprot  (awprot),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arprot  (arprot),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    while (!(awready && wready) && n < 50) begin tick(); n++; end
    check("aw_w_ready", {31'b0, awready && wready}, 32'd1);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] addr);
    int n = 0;
    araddr = addr; arvalid = 1'b1;
    while (!arready && n < 50) begin tick(); n++; end
    check("ar_ready", {31'b0, arready}, 32'd1);
    tick();
    arvalid = 1'b0;
  endtask

  task automatic b_take(input string tag, input logic [1:0] exp_resp);
    check({tag, "_bvalid"}, {31'b0, bvalid}, 32'd1);
    check({tag, "_bresp"}, {30'b0, bresp}, {30'b0, exp_resp});
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check({tag, "_bvalid_clr"}, {31'b0, bvalid}, 32'd0);
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
    ar_send(addr);
    check({tag, "_rvalid"}, {31'b0, rvalid}, 32'd1);
    check({tag, "_rdata"}, rdata, exp_data);
    check({tag, "_rresp"}, {30'b0, rresp}, {30'b0, exp_resp});
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check({tag, "_rvalid_clr"}, {31'b0, rvalid}, 32'd0);
  endtask

  task automatic write_chk(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp);
    aw_w(addr, data, strb);
    b_take(tag, exp_resp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    aresetn = 1'b0;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awprot = 3'b000; arprot = 3'b000;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) tick();
    check("rst_awready", {31'b0, awready}, 32'd0);
    check("rst_wready", {31'b0, wready}, 32'd0);
    check("rst_arready", {31'b0, arready}, 32'd0);
    check("rst_bvalid", {31'b0, bvalid}, 32'd0);
    check("rst_rvalid", {31'b0, rvalid}, 32'd0);
    check("rst_rdata", rdata, 32'h0);
    aresetn = 1'b1;
    tick();
    check("idle_awready", {31'b0, awready}, 32'd1);
    check("idle_wready", {31'b0, wready}, 32'd1);
    check("idle_arready", {31'b0, arready}, 32'd1);

    // 1: AW and W in the same cycle, response visible the next cycle
    write_chk("t1_wr", 32'h08, 32'h5, 4'hF, 2'b00);
    read_chk("t1_rd", 32'h08, 32'h5, 2'b00);

    // 2: W leads AW by 3 cycles, partial strobes
    wdata = 32'hA5A5A5A5; wstrb = 4'b0101; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    repeat (3) begin
      check("t2_wait_bvalid", {31'b0, bvalid}, 32'd0);
      check("t2_wait_wready", {31'b0, wready}, 32'd0);
      check("t2_wait_awready", {31'b0, awready}, 32'd1);
      tick();
    end
    awaddr = 32'h10; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    b_take("t2_wr", 2'b00);
    read_chk("t2_rd", 32'h10, 32'h00A500A5, 2'b00);

    // 3: index 32 is out of range; word 0 must not alias the write
    write_chk("t3_wr", 32'h80, 32'hDEADBEEF, 4'hF, 2'b10);
    read_chk("t3_rd_oob", 32'h80, 32'h0, 2'b10);
    read_chk("t3_rd_w0", 32'h00, 32'h0, 2'b00);

    // 4: responses stall while ready is low
    aw_w(32'h0C, 32'h12345678, 4'hF);
    repeat (5) begin
      check("t4_bvalid", {31'b0, bvalid}, 32'd1);
      check("t4_bresp", {30'b0, bresp}, 32'd0);
      check("t4_awready", {31'b0, awready}, 32'd0);
      check("t4_wready", {31'b0, wready}, 32'd0);
      tick();
    end
    b_take("t4_wr", 2'b00);
    ar_send(32'h0C);
    repeat (5) begin
      check("t4_rvalid", {31'b0, rvalid}, 32'd1);
      check("t4_rdata", rdata, 32'h12345678);
      check("t4_rresp", {30'b0, rresp}, 32'd0);
      check("t4_arready", {31'b0, arready}, 32'd0);
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("t4_rvalid_clr", {31'b0, rvalid}, 32'd0);
    check("t4_arready_back", {31'b0, arready}, 32'd1);

    // 5: write commit and AR capture on the same edge read the old word
    write_chk("t5_pre", 32'h04, 32'h7, 4'hF, 2'b00);
    awaddr = 32'h04; wdata = 32'h1; wstrb = 4'hF; araddr = 32'h04;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("t5_rvalid", {31'b0, rvalid}, 32'd1);
    check("t5_rdata_old", rdata, 32'h7);
    check("t5_bvalid", {31'b0, bvalid}, 32'd1);
    check("t5_bresp", {30'b0, bresp}, 32'd0);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    read_chk("t5_rd_new", 32'h04, 32'h1, 2'b00);

    // 6: reset pulse during WR_RESP abandons the response and clears memory
    aw_w(32'h08, 32'h99, 4'hF);
    check("t6_bvalid_pre", {31'b0, bvalid}, 32'd1);
    aresetn = 1'b0;
    #1;
    check("t6_awready_in_rst", {31'b0, awready}, 32'd0);
    check("t6_arready_in_rst", {31'b0, arready}, 32'd0);
    tick();
    aresetn = 1'b1;
    check("t6_bvalid_post", {31'b0, bvalid}, 32'd0);
    bready = 1'b1;
    repeat (2) begin
      tick();
      check("t6_no_late_b", {31'b0, bvalid}, 32'd0);
    end
    bready = 1'b0;
    for (int i = 0; i < 32; i++) read_chk("t6_clear", 32'(i * 4), 32'h0, 2'b00);
    write_chk("t6_wr", 32'h14, 32'hCAFEF00D, 4'hF, 2'b00);
    read_chk("t6_rd", 32'h14, 32'hCAFEF00D, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
